// File: rtl/pulse_decoder.sv
// pulse_decoder
//   Registered N-to-2^N one-hot decoder with a valid/ready handshake. An
//   accepted code drives exactly one select line for PULSE_LEN cycles, then
//   the block idles for GAP_LEN guard cycles before it accepts the next code.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   code    binary index of the line to strobe (N bits)
//   valid   code carries a request
//   ready   request can be accepted this cycle
//   y       one-hot strobe, all zero outside a pulse (2**N bits)
//   active  high while y is non-zero
//   done    one-cycle flag in the first cycle after a strobe ends
module pulse_decoder #(
  parameter int unsigned N         = 2,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      code,
  input  logic              valid,
  output logic              ready,
  output logic [(1<<N)-1:0] y,
  output logic              active,
  output logic              done
);

  localparam int unsigned YW   = 1 << N;
  localparam int unsigned MAXL = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned CW   = $clog2(MAXL + 1);

  localparam logic [YW-1:0] ONE        = YW'(1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;
  // Without a guard gap the next code is taken on the edge that ends the
  // current strobe, so ready must already be high in the last pulse cycle.
  localparam bit BACK2BACK = (GAP_LEN == 0);
  localparam bit READY_AT_LOAD = BACK2BACK && (PULSE_LEN == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [YW-1:0]   y_q;
  logic            active_q;
  logic            done_q;
  logic            ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (valid && ready_q) begin
            state_q  <= PULSE;
            y_q      <= ONE << code;
            active_q <= 1'b1;
            cnt_q    <= PULSE_LOAD;
            ready_q  <= READY_AT_LOAD;
          end
        end
        PULSE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            if (BACK2BACK && cnt_q == CW'(1)) begin
              ready_q <= 1'b1;
            end
          end else begin
            done_q <= 1'b1;
            if (!BACK2BACK) begin
              state_q  <= GAP;
              cnt_q    <= GAP_LOAD;
              y_q      <= '0;
              active_q <= 1'b0;
              ready_q  <= 1'b0;
            end else if (valid && ready_q) begin
              // Handover: the next strobe replaces y with no zero cycle.
              y_q     <= ONE << code;
              cnt_q   <= PULSE_LOAD;
              ready_q <= READY_AT_LOAD;
            end else begin
              state_q  <= IDLE;
              y_q      <= '0;
              active_q <= 1'b0;
              ready_q  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          y_q      <= '0;
          active_q <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign y      = y_q;
  assign active = active_q;
  assign done   = done_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_pulse_decoder.sv
// Bench for pulse_decoder: u0 runs with a one-cycle guard gap, u1 with none.
// Stimulus pushes expected strobes into queues; a negedge monitor pops them
// whenever a strobe run ends and compares line, length and the done flag.
module tb_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [1:0] c0 = '0, c1 = '0;
  logic       rdy0, rdy1, act0, act1, dn0, dn1;
  logic [3:0] y0, y1;

  always #5 clk = ~clk;

  pulse_decoder #(.N(2), .PULSE_LEN(4), .GAP_LEN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .code(c0), .valid(v0),
    .ready(rdy0), .y(y0), .active(act0), .done(dn0)
  );

  pulse_decoder #(.N(2), .PULSE_LEN(4), .GAP_LEN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .code(c1), .valid(v1),
    .ready(rdy1), .y(y1), .active(act1), .done(dn1)
  );

  typedef struct {
    logic [3:0]  y;
    int unsigned len;
  } strobe_t;

  strobe_t     sq0[$];
  strobe_t     sq1[$];
  int unsigned rq0[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------- monitor
  logic [3:0]  cur_y[2];
  int unsigned run_len[2];
  int unsigned rlow;

  initial begin
    cur_y[0] = '0; cur_y[1] = '0;
    run_len[0] = 0; run_len[1] = 0;
    rlow = 0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [3:0] yv;
      logic       dn, ac;
      bit         ended;
      strobe_t    e;
      yv = (d == 0) ? y0 : y1;
      dn = (d == 0) ? dn0 : dn1;
      ac = (d == 0) ? act0 : act1;
      if (!rst_n) begin
        cur_y[d] = '0;
        run_len[d] = 0;
        if (d == 0) rlow = 0;
      end else begin
        check($sformatf("active%0d", d), 32'(ac), 32'(yv != 4'b0000));
        ended = (yv != cur_y[d]) && (cur_y[d] != 4'b0000);
        if (ended) begin
          if ((d == 0 && sq0.size() == 0) || (d == 1 && sq1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe%0d: got y=%0h, expected none", d, cur_y[d]);
          end else begin
            e = (d == 0) ? sq0.pop_front() : sq1.pop_front();
            check($sformatf("strobe_y%0d", d), 32'(cur_y[d]), 32'(e.y));
            check($sformatf("strobe_len%0d", d), run_len[d], e.len);
          end
          check($sformatf("done_after%0d", d), 32'(dn), 32'd1);
        end else begin
          check($sformatf("done_stray%0d", d), 32'(dn), 32'd0);
        end
        if (yv != cur_y[d]) begin
          cur_y[d] = yv;
          run_len[d] = (yv != 4'b0000) ? 1 : 0;
        end else if (yv != 4'b0000) begin
          run_len[d]++;
        end
        if (d == 0) begin
          if (!rdy0) begin
            rlow++;
          end else if (rlow != 0) begin
            if (rq0.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_busy: got %0d low cycles, expected none", rlow);
            end else begin
              check("ready_low0", rlow, rq0.pop_front());
            end
            rlow = 0;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic wait_ready(input int d);
    int unsigned n;
    n = 0;
    while (((d == 0) ? rdy0 : rdy1) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout%0d: got ready=0 after %0d cycles, expected 1", d, n);
    end
  endtask

  task automatic req(input int d, input logic [1:0] code, input bit expect_it);
    strobe_t e;
    wait_ready(d);
    e.y = 4'b0001 << code;
    e.len = 4;
    if (d == 0) begin
      v0 = 1'b1; c0 = code;
      if (expect_it) begin sq0.push_back(e); rq0.push_back(5); end
    end else begin
      v1 = 1'b1; c1 = code;
      if (expect_it) sq1.push_back(e);
    end
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    strobe_t e;
    #1 rst_n = 1'b0;
    v0 = 1'b1; c0 = 2'd3;
    // Reset holds everything quiet even with a request pending.
    repeat (3) begin
      @(negedge clk);
      check("rst_y0", 32'(y0), 32'h0);
      check("rst_act0", 32'(act0), 32'h0);
      check("rst_done0", 32'(dn0), 32'h0);
      check("rst_ready0", 32'(rdy0), 32'h1);
      check("rst_y1", 32'(y1), 32'h0);
      check("rst_ready1", 32'(rdy1), 32'h1);
    end
    #2 rst_n = 1'b1;
    e.y = 4'b1000; e.len = 4;
    sq0.push_back(e);
    rq0.push_back(5);
    @(negedge clk);
    v0 = 1'b0;
    check("first_accept_y0", 32'(y0), 32'h8);

    // Full sweep of codes on the gapped decoder.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] cc;
      cc = 2'(i);
      req(0, cc, 1'b1);
    end

    // Requests during a pulse are ignored.
    wait_ready(0);
    v0 = 1'b1; c0 = 2'd1;
    e.y = 4'b0010; e.len = 4;
    sq0.push_back(e);
    rq0.push_back(5);
    @(negedge clk);
    c0 = 2'd2;
    repeat (2) begin
      @(negedge clk);
      check("ignored_y0", 32'(y0), 32'h2);
    end
    v0 = 1'b0;

    // Back-to-back strobes without a guard gap.
    wait_ready(1);
    v1 = 1'b1; c1 = 2'd2;
    e.y = 4'b0100; e.len = 4;
    sq1.push_back(e);
    @(negedge clk);
    c1 = 2'd0;
    e.y = 4'b0001; e.len = 4;
    sq1.push_back(e);
    repeat (3) @(negedge clk);
    check("handover_ready1", 32'(rdy1), 32'h1);
    check("handover_y1", 32'(y1), 32'h4);
    @(negedge clk);
    check("b2b_y1", 32'(y1), 32'h1);
    check("b2b_done1", 32'(dn1), 32'h1);
    v1 = 1'b0;
    repeat (4) @(negedge clk);
    check("end_y1", 32'(y1), 32'h0);
    check("end_done1", 32'(dn1), 32'h1);
    check("end_ready1", 32'(rdy1), 32'h1);

    // Asynchronous reset in the second cycle of a code-3 strobe.
    req(0, 2'd3, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_y0", 32'(y0), 32'h0);
    check("async_act0", 32'(act0), 32'h0);
    check("async_done0", 32'(dn0), 32'h0);
    check("async_ready0", 32'(rdy0), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready0", 32'(rdy0), 32'h1);

    // Idle hold: nothing moves with valid low.
    repeat (20) begin
      @(negedge clk);
      check("idle_y0", 32'(y0), 32'h0);
      check("idle_done0", 32'(dn0), 32'h0);
      check("idle_ready0", 32'(rdy0), 32'h1);
      check("idle_y1", 32'(y1), 32'h0);
      check("idle_ready1", 32'(rdy1), 32'h1);
    end

    check("pending_strobes0", sq0.size(), 0);
    check("pending_strobes1", sq1.size(), 0);
    check("pending_ready0", rq0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
